// File: rtl/imem_resp_if.sv
// Fetch-side request/response handshake between the fetch unit and imem_resp.
// master = fetch unit, slave = instruction memory responder.
interface imem_resp_if #(
    parameter int ADDR_W = 64
);
    logic              ce_i;
    logic [ADDR_W-1:0] addr_i;
    logic              ready_o;
    logic [31:0]       inst_o;
    logic              valid_o;
    logic              err_o;
    logic              resp_ready_i;

    modport master (
        output ce_i, addr_i, resp_ready_i,
        input  ready_o, inst_o, valid_o, err_o
    );

    modport slave (
        input  ce_i, addr_i, resp_ready_i,
        output ready_o, inst_o, valid_o, err_o
    );
endinterface

// File: rtl/imem_resp.sv
// Instruction-memory responder: word-addressed store, fixed or randomised response latency.
// Optional macro IMEM_RAND_LAT_EN adds 0..3 LFSR-driven cycles of extra latency per request.
module imem_resp #(
    parameter int                ADDR_W  = 64,
    parameter int                DEPTH   = 4096,
    parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(64'h0000_0000_8000_0000),
    parameter int                LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    imem_resp_if.slave        fetch,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [31:0]       ld_data_i
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_RAND_LAT_EN
    localparam int CNT_W = $clog2(LATENCY + 4);
`else
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  lat_s;
    logic              ready_r;
    logic              valid_r;
    logic              err_r;
    logic [31:0]       inst_r;
    logic [31:0]       mem_r [DEPTH];

    // Compare in ADDR_W+1 bits so the upper bound BASE+4*DEPTH cannot wrap.
    function automatic logic addr_fault(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] a_x;
        logic [ADDR_W:0] lo_x;
        logic [ADDR_W:0] hi_x;
        a_x  = {1'b0, a};
        lo_x = {1'b0, BASE};
        hi_x = lo_x + ((ADDR_W+1)'(DEPTH) << 2);
        return (a[1:0] != 2'b00) || (a_x < lo_x) || (a_x >= hi_x);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

`ifdef IMEM_RAND_LAT_EN
    logic [15:0] lfsr_r;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Extra latency source, advanced once per accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= 16'hACE1;
        end else if (state_r == ST_IDLE && fetch.ce_i && ready_r) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Effective latency for the request being accepted this cycle.
    always_comb begin
        lat_s = CNT_W'(LATENCY) + CNT_W'(lfsr_r[1:0]);
    end
`else
    // Effective latency for the request being accepted this cycle.
    always_comb begin
        lat_s = CNT_W'(LATENCY);
    end
`endif

    // Load port; out-of-range or misaligned writes are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (rst) begin
            if (ld_we_i && !addr_fault(ld_addr_i)) begin
                mem_r[word_index(ld_addr_i)] <= ld_data_i;
            end
        end
    end

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            inst_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fetch.ce_i && ready_r) begin
                        addr_r  <= fetch.addr_i;
                        cnt_r   <= lat_s;
                        ready_r <= 1'b0;
                        state_r <= (lat_s == {CNT_W{1'b0}}) ? ST_RESP : ST_WAIT;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // First RESP cycle performs the read; later cycles hold until handshake.
                    if (!valid_r) begin
                        valid_r <= 1'b1;
                        if (addr_fault(addr_r)) begin
                            err_r  <= 1'b1;
                            inst_r <= NOP;
                        end else begin
                            err_r  <= 1'b0;
                            inst_r <= mem_r[word_index(addr_r)];
                        end
                    end else if (fetch.resp_ready_i) begin
                        valid_r <= 1'b0;
                        err_r   <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    ready_r <= 1'b0;
                    valid_r <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign fetch.ready_o = ready_r;
    assign fetch.valid_o = valid_r;
    assign fetch.err_o   = err_r;
    assign fetch.inst_o  = inst_r;

endmodule

// File: tb/tb_imem_resp.sv
// Directed self-checking bench for imem_resp: one instance at LATENCY=1, one at LATENCY=4.
module tb_imem_resp;

    localparam int LAT  = 1;
    localparam int LAT4 = 4;
`ifdef IMEM_RAND_LAT_EN
    localparam int RX = 3;
`else
    localparam int RX = 0;
`endif

    logic        clk;
    logic        rst;
    logic        ld_we;
    logic [63:0] ld_addr;
    logic [31:0] ld_data;
    int          n_cmp;
    int          n_bad;

    imem_resp_if #(.ADDR_W(64)) f  ();
    imem_resp_if #(.ADDR_W(64)) f4 ();

    imem_resp #(.ADDR_W(64), .DEPTH(4096), .BASE(64'h0000_0000_8000_0000), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .fetch(f.slave),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    imem_resp #(.ADDR_W(64), .DEPTH(4096), .BASE(64'h0000_0000_8000_0000), .LATENCY(LAT4)) dut4 (
        .clk(clk), .rst(rst), .fetch(f4.slave),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [63:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    // Issue one request on dut (sel=0) or dut4 (sel=1); lat = edges from accept to valid_o.
    task automatic do_req(input logic sel, input logic [63:0] a, output int lat,
                          output logic [31:0] inst, output logic err, output logic to);
        int k;
        to = 1'b0;
        @(negedge clk);
        if (sel) begin f4.ce_i = 1'b1; f4.addr_i = a; end
        else     begin f.ce_i  = 1'b1; f.addr_i  = a; end
        k = 0;
        while (((sel ? f4.ready_o : f.ready_o) !== 1'b1) && k < 20) begin
            @(negedge clk); k++;
        end
        if (k >= 20) to = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (sel) f4.ce_i = 1'b0; else f.ce_i = 1'b0;
        lat = 0;
        while (((sel ? f4.valid_o : f.valid_o) !== 1'b1) && lat < 40) begin
            @(negedge clk); lat++;
        end
        if (lat >= 40) to = 1'b1;
        inst = sel ? f4.inst_o : f.inst_o;
        err  = sel ? f4.err_o  : f.err_o;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (f.valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", f.valid_o); end
        n_cmp++; if (f.err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", f.err_o); end
        n_cmp++; if (f.inst_o !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h want 0", f.inst_o); end
        n_cmp++; if (f.ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", f.ready_o); end
        n_cmp++; if (f4.valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid4: got %b want 0", f4.valid_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if (f.ready_o !== 1'b0) begin n_bad++; $display("FAIL rel_ready_now: got %b want 0", f.ready_o); end
        @(negedge clk);
        n_cmp++; if (f.ready_o !== 1'b1) begin n_bad++; $display("FAIL rel_ready_next: got %b want 1", f.ready_o); end
        n_cmp++; if (f4.ready_o !== 1'b1) begin n_bad++; $display("FAIL rel_ready4: got %b want 1", f4.ready_o); end
    endtask

    task automatic test_basic;
        int lat; logic [31:0] inst; logic err, to;
        load(64'h8000_0000, 32'h0000_0297);
        f.resp_ready_i = 1'b1;
        do_req(1'b0, 64'h8000_0000, lat, inst, err, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout: got timeout want response"); end
        n_cmp++; if (lat < LAT+1 || lat > LAT+1+RX) begin n_bad++; $display("FAIL basic_lat: got %0d want %0d", lat, LAT+1); end
        n_cmp++; if (inst !== 32'h0000_0297) begin n_bad++; $display("FAIL basic_inst: got %h want 00000297", inst); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b want 0", err); end
        n_cmp++; if (f.ready_o !== 1'b0) begin n_bad++; $display("FAIL basic_ready_busy: got %b want 0", f.ready_o); end
        @(negedge clk);
        n_cmp++; if (f.valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_valid_clr: got %b want 0", f.valid_o); end
        n_cmp++; if (f.ready_o !== 1'b1) begin n_bad++; $display("FAIL basic_ready_after: got %b want 1", f.ready_o); end
        n_cmp++; if (f.inst_o !== 32'h0000_0297) begin n_bad++; $display("FAIL basic_inst_keep: got %h want 00000297", f.inst_o); end
    endtask

    task automatic test_backpressure;
        int lat; logic [31:0] inst; logic err, to;
        load(64'h8000_0004, 32'h0002_8823);
        f.resp_ready_i = 1'b0;
        do_req(1'b0, 64'h8000_0004, lat, inst, err, to);
        n_cmp++; if (to || inst !== 32'h0002_8823) begin n_bad++; $display("FAIL bp_inst: got %h want 00028823 (to=%b)", inst, to); end
        f.ce_i = 1'b1; f.addr_i = 64'h8000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (f.valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, f.valid_o); end
            n_cmp++; if (f.inst_o !== 32'h0002_8823) begin n_bad++; $display("FAIL bp_hold[%0d]: got %h want 00028823", i, f.inst_o); end
            n_cmp++; if (f.ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, f.ready_o); end
        end
        f.resp_ready_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (f.valid_o !== 1'b0 || f.ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", f.valid_o, f.ready_o); end
        @(posedge clk);
        @(negedge clk);
        f.ce_i = 1'b0;
        lat = 0;
        while (f.valid_o !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        n_cmp++; if (lat < LAT+1 || lat > LAT+1+RX) begin n_bad++; $display("FAIL bp_second_lat: got %0d want %0d", lat, LAT+1); end
        n_cmp++; if (f.inst_o !== 32'h0000_0297) begin n_bad++; $display("FAIL bp_second_inst: got %h want 00000297", f.inst_o); end
    endtask

    task automatic test_faults;
        int lat; logic [31:0] inst; logic err, to;
        f.resp_ready_i = 1'b1;
        do_req(1'b0, 64'h8000_0002, lat, inst, err, to);
        n_cmp++; if (to || err !== 1'b1) begin n_bad++; $display("FAIL flt_misalign_err: got %b want 1", err); end
        n_cmp++; if (inst !== 32'h0000_0013) begin n_bad++; $display("FAIL flt_misalign_inst: got %h want 00000013", inst); end
        do_req(1'b0, 64'h7FFF_FFFC, lat, inst, err, to);
        n_cmp++; if (to || err !== 1'b1) begin n_bad++; $display("FAIL flt_below_err: got %b want 1", err); end
        do_req(1'b0, 64'h8000_4000, lat, inst, err, to);
        n_cmp++; if (to || err !== 1'b1) begin n_bad++; $display("FAIL flt_top_err: got %b want 1", err); end
        n_cmp++; if (inst !== 32'h0000_0013) begin n_bad++; $display("FAIL flt_top_inst: got %h want 00000013", inst); end
        do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, lat, inst, err, to);
        n_cmp++; if (to || err !== 1'b1) begin n_bad++; $display("FAIL flt_wrap_err: got %b want 1", err); end
        load(64'h8000_3FFC, 32'hCAFE_0001);
        do_req(1'b0, 64'h8000_3FFC, lat, inst, err, to);
        n_cmp++; if (to || err !== 1'b0) begin n_bad++; $display("FAIL last_word_err: got %b want 0", err); end
        n_cmp++; if (inst !== 32'hCAFE_0001) begin n_bad++; $display("FAIL last_word_inst: got %h want cafe0001", inst); end
        load(64'h8000_0001, 32'h0BAD_0BAD);
        do_req(1'b0, 64'h8000_0000, lat, inst, err, to);
        n_cmp++; if (to || inst !== 32'h0000_0297) begin n_bad++; $display("FAIL ld_misalign_drop: got %h want 00000297", inst); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ld_misalign_err: got %b want 0", err); end
    endtask

    task automatic test_same_cycle_write;
        int lat, k; logic [31:0] inst; logic err, to;
        load(64'h8000_0008, 32'h0010_0073);
        f.resp_ready_i = 1'b1;
`ifndef IMEM_RAND_LAT_EN
        @(negedge clk);
        f.ce_i = 1'b1; f.addr_i = 64'h8000_0008;
        k = 0;
        while (f.ready_o !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        f.ce_i = 1'b0;
        repeat (LAT) @(negedge clk);
        n_cmp++; if (f.valid_o !== 1'b0) begin n_bad++; $display("FAIL sc_early_valid: got %b want 0", f.valid_o); end
        ld_we = 1'b1; ld_addr = 64'h8000_0008; ld_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ld_we = 1'b0;
        n_cmp++; if (f.valid_o !== 1'b1) begin n_bad++; $display("FAIL sc_valid: got %b want 1", f.valid_o); end
        n_cmp++; if (f.inst_o !== 32'h0010_0073) begin n_bad++; $display("FAIL sc_old_data: got %h want 00100073", f.inst_o); end
`else
        load(64'h8000_0008, 32'hDEAD_BEEF);
`endif
        do_req(1'b0, 64'h8000_0008, lat, inst, err, to);
        n_cmp++; if (to || inst !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sc_new_data: got %h want deadbeef", inst); end
    endtask

    task automatic test_reset_midop;
        int lat, k; logic [31:0] inst; logic err, to; logic saw;
        load(64'h8000_0010, 32'h1234_5678);
        f4.resp_ready_i = 1'b1;
        @(negedge clk);
        f4.ce_i = 1'b1; f4.addr_i = 64'h8000_0010;
        k = 0;
        while (f4.ready_o !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        f4.ce_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (f4.valid_o !== 1'b0 || f4.ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_in_wait: got v=%b r=%b want 0 0", f4.valid_o, f4.ready_o); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (f4.ready_o !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", f4.ready_o); end
        saw = f4.valid_o;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            saw = saw | f4.valid_o;
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL mid_no_resp: got valid=%b want 0", saw); end
        do_req(1'b1, 64'h8000_0010, lat, inst, err, to);
        n_cmp++; if (to || lat < LAT4+1 || lat > LAT4+1+RX) begin n_bad++; $display("FAIL mid_lat4: got %0d want %0d", lat, LAT4+1); end
        n_cmp++; if (inst !== 32'h1234_5678) begin n_bad++; $display("FAIL mid_store4: got %h want 12345678", inst); end
        do_req(1'b0, 64'h8000_0000, lat, inst, err, to);
        n_cmp++; if (to || inst !== 32'h0000_0297) begin n_bad++; $display("FAIL mid_store: got %h want 00000297", inst); end
    endtask

    task automatic test_latency_sweep;
        int lat; logic [31:0] inst; logic err, to; logic [31:0] exp_w;
        f.resp_ready_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp_w = i[0] ? 32'h0002_8823 : 32'h0000_0297;
            do_req(1'b0, i[0] ? 64'h8000_0004 : 64'h8000_0000, lat, inst, err, to);
            n_cmp++; if (to || lat < LAT+1 || lat > LAT+1+RX) begin n_bad++; $display("FAIL sweep_lat[%0d]: got %0d want %0d..%0d", i, lat, LAT+1, LAT+1+RX); end
            n_cmp++; if (inst !== exp_w) begin n_bad++; $display("FAIL sweep_inst[%0d]: got %h want %h", i, inst, exp_w); end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b0;
        ld_we = 1'b0; ld_addr = 64'h0; ld_data = 32'h0;
        f.ce_i = 1'b0; f.addr_i = 64'h0; f.resp_ready_i = 1'b0;
        f4.ce_i = 1'b0; f4.addr_i = 64'h0; f4.resp_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_faults();
        test_same_cycle_write();
        test_reset_midop();
        test_latency_sweep();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
